log_divider_pipe: RTL and testbench

//  Mitchell log-domain approximate divider; inverse operation to the log multiplier in the systolic PE datapath.
//  Q ~= 2^(log2|A| - log2|B|), computed with leading-one detection, log subtraction and an antilog shift.
//  3-stage pipeline with valid/ready handshakes on both sides.

---
 rtl/log_arith_pkg.sv | 29 ++
 rtl/log_antilog.sv | 44 ++++
 rtl/lopd.sv | 20 ++
 rtl/log_divider_pipe.sv | 152 +++++++++++++++
 tb/tb_log_divider_pipe.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/log_arith_pkg.sv
// Shared log-domain arithmetic helpers: width math used by the Mitchell multiplier and divider.
package log_arith_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Mantissa bits below the leading one, aligned to the wider operand
  function automatic int unsigned frac_bits(input int unsigned wa, input int unsigned wb);
    return max_u(wa, wb) - 1;
  endfunction

  function automatic int unsigned k_bits(input int unsigned wa, input int unsigned wb);
    return clog2(max_u(wa, wb));
  endfunction

  // Signed log difference: characteristic, mantissa, sign and borrow headroom
  function automatic int unsigned diff_bits(input int unsigned wa, input int unsigned wb);
    return k_bits(wa, wb) + frac_bits(wa, wb) + 2;
  endfunction

endpackage

// File: rtl/log_antilog.sv
// Antilog core: rebuilds {1,xq} * 2^(kq - XQ_W + FRAC_W), truncated, with saturation to the Q range.
module log_antilog
  import log_arith_pkg::*;
#(
  parameter int unsigned XQ_W    = 15,
  parameter int unsigned KQ_W    = 6,
  parameter int unsigned FRAC_W  = 0,
  parameter int unsigned WIDTH_Q = 16,
  parameter bit          SIGNED  = 1'b0
) (
  input  logic [XQ_W-1:0]        xq,
  input  logic signed [KQ_W-1:0] kq,
  output logic [WIDTH_Q-1:0]     m,
  output logic                   sat
);

  localparam int unsigned MANT_W = XQ_W + 1;
  localparam int unsigned CMP_W  = max_u(MANT_W + FRAC_W + 1, WIDTH_Q + 1);
  localparam int unsigned LMAX   = CMP_W - MANT_W;
  localparam logic [WIDTH_Q-1:0] QMAX = SIGNED ? {1'b0, {(WIDTH_Q-1){1'b1}}} : {WIDTH_Q{1'b1}};

  logic [MANT_W-1:0] mant;
  logic [CMP_W-1:0]  wide;
  logic              ovf;
  int                sh;

  assign mant = {1'b1, xq};

  // Any left shift beyond LMAX pushes the implicit one out of range
  always_comb begin
    sh   = int'(kq) - int'(XQ_W) + int'(FRAC_W);
    wide = '0;
    ovf  = 1'b0;
    if (sh >= 0) begin
      if (sh > int'(LMAX)) ovf = 1'b1;
      else                 wide = CMP_W'(mant) << sh;
    end else if (-sh <= int'(XQ_W)) begin
      wide = CMP_W'(mant) >> (-sh);
    end
    sat = ovf || (wide > CMP_W'(QMAX));
    m   = sat ? QMAX : wide[WIDTH_Q-1:0];
  end

endmodule

// File: rtl/lopd.sv
// Leading-one position detector: index of the most significant set bit, plus an all-zero flag.
module lopd #(
  parameter int unsigned W   = 16,
  parameter int unsigned P_W = 4
) (
  input  logic [W-1:0]   x,
  output logic [P_W-1:0] pos,
  output logic           zero
);

  always_comb begin
    pos = '0;
    for (int i = 0; i < W; i++) begin
      if (x[i]) pos = P_W'(i);
    end
  end

  assign zero = ~|x;

endmodule

// File: rtl/log_divider_pipe.sv
// Mitchell approximate divider Q ~= 2^(log2|A| - log2|B|), three register stages with valid/ready.
module log_divider_pipe
  import log_arith_pkg::*;
#(
  parameter int unsigned WIDTH_A = 16,
  parameter int unsigned WIDTH_B = 16,
  parameter int unsigned WIDTH_Q = 16,
  parameter int unsigned FRAC_W  = 0,
  parameter bit          SIGNED  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] A,
  input  logic [WIDTH_B-1:0] B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_Q-1:0] Q,
  output logic               div_zero,
  output logic               sat
);

  localparam int unsigned F    = frac_bits(WIDTH_A, WIDTH_B);
  localparam int unsigned MAXW = F + 1;
  localparam int unsigned K_W  = k_bits(WIDTH_A, WIDTH_B);
  localparam int unsigned D_W  = diff_bits(WIDTH_A, WIDTH_B);
  localparam int unsigned KQ_W = D_W - F;
  localparam logic [WIDTH_Q-1:0] QMAX = SIGNED ? {1'b0, {(WIDTH_Q-1){1'b1}}} : {WIDTH_Q{1'b1}};

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // S1 combinational: magnitudes, leading-one positions, left-aligned mantissas
  logic               a_neg_c, b_neg_c, za_c, zb_c;
  logic [WIDTH_A-1:0] mag_a_c;
  logic [WIDTH_B-1:0] mag_b_c;
  logic [MAXW-1:0]    ext_a_c, ext_b_c;
  logic [K_W-1:0]     ka_c, kb_c;
  logic [F-1:0]       xa_c, xb_c;

  assign a_neg_c = SIGNED && A[WIDTH_A-1];
  assign b_neg_c = SIGNED && B[WIDTH_B-1];
  assign mag_a_c = a_neg_c ? -A : A;
  assign mag_b_c = b_neg_c ? -B : B;
  assign ext_a_c = MAXW'(mag_a_c);
  assign ext_b_c = MAXW'(mag_b_c);

  lopd #(.W(MAXW), .P_W(K_W)) u_lopd_a (.x(ext_a_c), .pos(ka_c), .zero(za_c));
  lopd #(.W(MAXW), .P_W(K_W)) u_lopd_b (.x(ext_b_c), .pos(kb_c), .zero(zb_c));

  assign xa_c = F'(ext_a_c << (K_W'(F) - ka_c));
  assign xb_c = F'(ext_b_c << (K_W'(F) - kb_c));

  logic           s1_valid, s1_neg, s1_neg_a, s1_za, s1_zb;
  logic [K_W-1:0] s1_ka, s1_kb;
  logic [F-1:0]   s1_xa, s1_xb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_neg   <= 1'b0;
      s1_neg_a <= 1'b0;
      s1_za    <= 1'b0;
      s1_zb    <= 1'b0;
      s1_ka    <= '0;
      s1_kb    <= '0;
      s1_xa    <= '0;
      s1_xb    <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_neg   <= a_neg_c ^ b_neg_c;
      s1_neg_a <= a_neg_c;
      s1_za    <= za_c;
      s1_zb    <= zb_c;
      s1_ka    <= ka_c;
      s1_kb    <= kb_c;
      s1_xa    <= xa_c;
      s1_xb    <= xb_c;
    end
  end

  // S2: log-domain subtraction; a mantissa borrow lowers the characteristic by one
  logic signed [D_W-1:0] d_c;
  assign d_c = signed'({2'b00, s1_ka, s1_xa}) - signed'({2'b00, s1_kb, s1_xb});

  logic                  s2_valid, s2_neg, s2_neg_a, s2_za, s2_zb;
  logic signed [D_W-1:0] s2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_neg   <= 1'b0;
      s2_neg_a <= 1'b0;
      s2_za    <= 1'b0;
      s2_zb    <= 1'b0;
      s2_d     <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_neg   <= s1_neg;
      s2_neg_a <= s1_neg_a;
      s2_za    <= s1_za;
      s2_zb    <= s1_zb;
      s2_d     <= d_c;
    end
  end

  // S3: antilog, sign restore, zero-operand overrides (divide-by-zero wins)
  logic signed [KQ_W-1:0] kq_c;
  logic [F-1:0]           xq_c;
  logic [WIDTH_Q-1:0]     m_c, q_c;
  logic                   m_sat_c, dz_c, sat_c;

  assign kq_c = s2_d[D_W-1:F];
  assign xq_c = s2_d[F-1:0];

  log_antilog #(
    .XQ_W(F), .KQ_W(KQ_W), .FRAC_W(FRAC_W), .WIDTH_Q(WIDTH_Q), .SIGNED(SIGNED)
  ) u_antilog (
    .xq(xq_c), .kq(kq_c), .m(m_c), .sat(m_sat_c)
  );

  always_comb begin
    q_c   = s2_neg ? -m_c : m_c;
    dz_c  = 1'b0;
    sat_c = m_sat_c;
    if (s2_zb) begin
      q_c   = s2_neg_a ? -QMAX : QMAX;
      dz_c  = 1'b1;
      sat_c = 1'b0;
    end else if (s2_za) begin
      q_c   = '0;
      sat_c = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      Q         <= '0;
      div_zero  <= 1'b0;
      sat       <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      Q         <= q_c;
      div_zero  <= dz_c;
      sat       <= sat_c;
    end
  end

endmodule

// File: tb/tb_log_divider_pipe.sv
// Bench for log_divider_pipe: three parameterisations driven in lockstep, checked against a real-valued Mitchell model.
module tb_log_divider_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [15:0] a, b;

  logic        in_ready_d, in_ready_f, in_ready_s;
  logic        out_valid_d, out_valid_f, out_valid_s;
  logic [15:0] q_d, q_f, q_s;
  logic        dz_d, dz_f, dz_s, sat_d, sat_f, sat_s;

  always #5 clk = ~clk;

  log_divider_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d), .A(a), .B(b),
    .out_valid(out_valid_d), .out_ready(out_ready), .Q(q_d), .div_zero(dz_d), .sat(sat_d)
  );

  log_divider_pipe #(.FRAC_W(4)) u_frac (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_f), .A(a), .B(b),
    .out_valid(out_valid_f), .out_ready(out_ready), .Q(q_f), .div_zero(dz_f), .sat(sat_f)
  );

  log_divider_pipe #(.SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .A(a), .B(b),
    .out_valid(out_valid_s), .out_ready(out_ready), .Q(q_s), .div_zero(dz_s), .sat(sat_s)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  int          pushes = 0;
  int          pops = 0;
  bit          hold_pend = 1'b0;
  logic [17:0] held;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic real log2m(input longint x);
    int k;
    k = 0;
    while ((longint'(1) << (k + 1)) <= x) k++;
    return real'(k) + real'(x - (longint'(1) << k)) / real'(longint'(1) << k);
  endfunction

  // Returns {div_zero, sat, Q}
  function automatic logic [17:0] model(input logic [15:0] ra, input logic [15:0] rb,
                                        input bit sgn, input int fracw);
    bit     neg_a, neg_b, neg, s;
    longint ma, mb, qmax, mi;
    real    d, f, m, scale;
    int     kq, e;
    neg_a = sgn && ra[15];
    neg_b = sgn && rb[15];
    ma    = neg_a ? 65536 - longint'(ra) : longint'(ra);
    mb    = neg_b ? 65536 - longint'(rb) : longint'(rb);
    neg   = neg_a ^ neg_b;
    qmax  = sgn ? 32767 : 65535;
    if (mb == 0) return {1'b1, 1'b0, 16'(neg_a ? -qmax : qmax)};
    if (ma == 0) return 18'd0;
    d  = log2m(ma) - log2m(mb);
    kq = int'($floor(d));
    f  = d - real'(kq);
    e  = kq + fracw;
    scale = 1.0;
    if (e >= 0) repeat (e) scale = scale * 2.0;
    else        repeat (-e) scale = scale / 2.0;
    m = (1.0 + f) * scale;
    s = 1'b0;
    if (m >= real'(qmax) + 1.0) begin
      s  = 1'b1;
      mi = qmax;
    end else begin
      mi = longint'($floor(m));
    end
    return {1'b0, s, 16'(neg ? -mi : mi)};
  endfunction

  function automatic logic [15:0] rnd_op();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 16'd0;
    if (r < 3) return 16'($urandom_range(1, 15));
    return 16'($urandom);
  endfunction

  // One clock: bookkeeping at the falling edge, then advance past the rising edge
  task automatic tick();
    logic [15:0] ea, eb;
    @(negedge clk);
    if (hold_pend) begin
      check("hold_valid", 32'(out_valid_d), 32'd1);
      check("hold_data", 32'({dz_d, sat_d, q_d}), 32'(held));
    end
    if (out_valid_d && out_ready) begin
      check("pop_nonempty", 32'(qa.size() > 0), 32'd1);
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        pops++;
        check("lockstep_valid", 32'({out_valid_f, out_valid_s}), 32'd3);
        check($sformatf("q_def a=%0h b=%0h", ea, eb), 32'({dz_d, sat_d, q_d}), 32'(model(ea, eb, 1'b0, 0)));
        check($sformatf("q_frac a=%0h b=%0h", ea, eb), 32'({dz_f, sat_f, q_f}), 32'(model(ea, eb, 1'b0, 4)));
        check($sformatf("q_sgn a=%0h b=%0h", ea, eb), 32'({dz_s, sat_s, q_s}), 32'(model(ea, eb, 1'b1, 0)));
      end
    end
    if (in_valid && in_ready_d) begin
      check("lockstep_ready", 32'({in_ready_f, in_ready_s}), 32'd3);
      qa.push_back(a);
      qb.push_back(b);
      pushes++;
    end
    hold_pend = out_valid_d && !out_ready;
    held      = {dz_d, sat_d, q_d};
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((qa.size() > 0 || out_valid_d) && n < 20) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(qa.size()), 32'd0);
  endtask

  task automatic directed(input logic [15:0] da, input logic [15:0] db, input int which,
                          input logic [15:0] exp_q, input logic exp_dz);
    int          lat;
    logic [15:0] got_q;
    logic        got_dz;
    drain();
    a = da;
    b = db;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid_d && lat < 10) begin
      tick();
      lat++;
    end
    check($sformatf("latency a=%0h b=%0h", da, db), 32'(lat), 32'd3);
    case (which)
      1:       begin got_q = q_f; got_dz = dz_f; end
      2:       begin got_q = q_s; got_dz = dz_s; end
      default: begin got_q = q_d; got_dz = dz_d; end
    endcase
    check($sformatf("dir_q inst=%0d a=%0h b=%0h", which, da, db), 32'(got_q), 32'(exp_q));
    check($sformatf("dir_dz inst=%0d a=%0h b=%0h", which, da, db), 32'(got_dz), 32'(exp_dz));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int p0, o0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid_d), 32'd0);
    check("rst_q", 32'({dz_d, sat_d, q_d}), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready_d), 32'd1);

    directed(16'd100, 16'd10, 0, 16'd10, 1'b0);
    directed(16'd100, 16'd10, 1, 16'd168, 1'b0);
    directed(16'd64, 16'd8, 0, 16'd8, 1'b0);
    directed(16'd7, 16'd9, 0, 16'd0, 1'b0);
    directed(16'd7, 16'd9, 1, 16'd13, 1'b0);
    directed(16'hFF9C, 16'd10, 2, 16'hFFF6, 1'b0);
    directed(16'hFF9C, 16'hFFF6, 2, 16'd10, 1'b0);
    directed(16'd5, 16'd0, 0, 16'hFFFF, 1'b1);
    directed(16'd0, 16'd3, 0, 16'd0, 1'b0);
    directed(16'h8000, 16'd1, 2, 16'h8001, 1'b0);

    // Six operands with the consumer stalled for five cycles mid-stream
    drain();
    p0 = pushes;
    o0 = pops;
    for (int c = 0; c < 16; c++) begin
      in_valid  = (pushes - p0) < 6;
      out_ready = !(c >= 4 && c < 9);
      a = rnd_op();
      b = rnd_op();
      if (c == 6) begin
        #1;
        check("stall_in_ready", 32'(in_ready_d), 32'd0);
      end
      tick();
    end
    drain();
    check("stall_count_in", 32'(pushes - p0), 32'd6);
    check("stall_count_out", 32'(pops - o0), 32'd6);

    // Random traffic with random back-pressure
    for (int c = 0; c < 400; c++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      a = rnd_op();
      b = rnd_op();
      tick();
    end
    drain();
    check("random_count", 32'(pops), 32'(pushes));

    // Asynchronous reset with three operands in flight
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom);
      b = 16'($urandom_range(1, 65535));
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid_d), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(out_valid_d), 32'd0);
    check("rst_async_q", 32'({dz_d, sat_d, q_d}), 32'd0);
    qa.delete();
    qb.delete();
    hold_pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("no_stale", 32'(out_valid_d), 32'd0);
      tick();
    end
    directed(16'd64, 16'd8, 0, 16'd8, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
